// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, sizes and reference vectors for the serial AES host
package aes_pkg;

    localparam int BLOCK_BITS = 128;
    localparam int KEY_BITS   = 128;
    localparam int SEND_BITS  = 256;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RECV,
        ST_DONE
    } state_e;

    // Bit counter step that holds at the phase limit instead of wrapping.
    function automatic logic [8:0] sat_inc(input logic [8:0] v, input logic [8:0] lim);
        return (v >= lim) ? lim : v + 9'd1;
    endfunction

endpackage

// File: rtl/aes_serial_host_if.sv
// rtl/aes_serial_host_if.sv - request/response handshake and serial link bundle
interface aes_serial_host_if;
    import aes_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [BLOCK_BITS-1:0] plaintext;
    logic [KEY_BITS-1:0]   key;
    logic                  out_valid;
    logic                  out_ready;
    logic [BLOCK_BITS-1:0] ciphertext;
    logic                  cs;
    logic                  miso;
    logic                  mosi;
    logic                  busy;

    modport slave (
        input  in_valid, plaintext, key, out_ready, mosi,
        output in_ready, out_valid, ciphertext, cs, miso, busy
    );

    modport master (
        output in_valid, plaintext, key, out_ready, mosi,
        input  in_ready, out_valid, ciphertext, cs, miso, busy
    );

endinterface

// File: rtl/aes_piso_sipo.sv
// rtl/aes_piso_sipo.sv - shift register with parallel load, right shift and indexed bit capture
module aes_piso_sipo
    import aes_pkg::*;
#(
    parameter int WIDTH = BLOCK_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_load,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_shift,
    input  logic                     i_sin,
    input  logic                     i_capture,
    input  logic [$clog2(WIDTH)-1:0] i_idx,
    output logic [WIDTH-1:0]         o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_data;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end else if (i_capture) begin
            r_q[i_idx] <= i_sin;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/aes_serial_host.sv
// rtl/aes_serial_host.sv - serial host framing plaintext/key out and ciphertext back from an Encrypt core
module aes_serial_host
    import aes_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    aes_serial_host_if.slave bus
);

    localparam logic [8:0] SEND_LAST = 9'(SEND_BITS - 1);
    localparam logic [8:0] RECV_LAST = 9'(BLOCK_BITS - 1);
    localparam logic [8:0] WAIT_LAST = 9'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e               r_state;
    logic [8:0]           r_cnt;
    logic [SEND_BITS-1:0] r_tx;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_cs;
    logic                 r_busy;
    logic                 w_capture;

    assign w_capture = (r_state == ST_RECV);

    // Ciphertext register: bit j is written only at the edge ending receive cycle j.
    aes_piso_sipo #(.WIDTH(BLOCK_BITS)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .i_load    (1'b0),
        .i_data    ('0),
        .i_shift   (1'b0),
        .i_sin     (bus.mosi),
        .i_capture (w_capture),
        .i_idx     (r_cnt[6:0]),
        .o_q       (bus.ciphertext)
    );

    // The transmit register drains to zero after bit 255, so miso idles low outside SEND.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_tx        <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cs        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_tx       <= {bus.key, bus.plaintext};
                        r_cnt      <= '0;
                        r_state    <= ST_SEND;
                        r_in_ready <= 1'b0;
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_SEND: begin
                    r_tx <= {1'b0, r_tx[SEND_BITS-1:1]};
                    if (r_cnt == SEND_LAST) begin
                        r_cnt   <= '0;
                        r_state <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_RECV;
                    end else begin
                        r_cnt <= sat_inc(r_cnt, SEND_LAST);
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == WAIT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= ST_RECV;
                    end else begin
                        r_cnt <= sat_inc(r_cnt, WAIT_LAST);
                    end
                end
                ST_RECV: begin
                    if (r_cnt == RECV_LAST) begin
                        r_cnt       <= '0;
                        r_state     <= ST_DONE;
                        r_cs        <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= sat_inc(r_cnt, RECV_LAST);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.cs        = r_cs;
    assign bus.miso      = r_tx[0];
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_aes_serial_host.sv
// tb/tb_aes_serial_host.sv - self-checking bench with a behavioural AES-128 Encrypt core model
module tb_aes_serial_host;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_serial_host_if if0 ();
    aes_serial_host_if if5 ();

    aes_serial_host #(.WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    aes_serial_host #(.WAIT_CYCLES(5)) dut5 (.clk(clk), .rst(rst), .bus(if5.slave));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Behavioural AES-128 built from GF(2^8) arithmetic.
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] w [176];
        logic [7:0] tmp [4];
        logic [7:0] rc, b0, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            s[i] = pt[127-8*i -: 8];
            w[i] = key[127-8*i -: 8];
        end
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1)+j];
            if (i % 4 == 0) begin
                b0     = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rc;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[b0];
                rc     = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[4*i+j] = w[4*(i-4)+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] ^= w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Encrypt core model: counts cs-low cycles, collects 256 bits, replies d cycles after the last one.
    int           c_cnt   [2] = '{0, 0};
    int           c_frame [2] = '{0, 0};
    int           miso_bad[2] = '{0, 0};
    logic [255:0] c_rx    [2];
    logic [255:0] c_last  [2];
    logic [127:0] c_ct    [2];
    logic         m0, m5;

    task automatic core_step(input int id, input int d, input logic cs, input logic miso, output logic mosi);
        mosi = 1'b0;
        if (cs) begin
            if (miso) miso_bad[id]++;
            if (c_cnt[id] != 0) begin
                c_frame[id] = c_cnt[id];
                c_last[id]  = c_rx[id];
            end
            c_cnt[id] = 0;
        end else begin
            if (c_cnt[id] < 256) c_rx[id][c_cnt[id]] = miso;
            else if (miso) miso_bad[id]++;
            if (c_cnt[id] == 255) c_ct[id] = aes_enc(c_rx[id][127:0], c_rx[id][255:128]);
            if (c_cnt[id] >= 256 + d && c_cnt[id] < 384 + d) mosi = c_ct[id][c_cnt[id]-256-d];
            c_cnt[id]++;
        end
    endtask

    always @(negedge clk) begin
        core_step(0, 0, if0.cs, if0.miso, m0);
        if0.mosi = m0;
        core_step(1, 5, if5.cs, if5.miso, m5);
        if5.mosi = m5;
    end

    typedef struct packed {
        logic         ir;
        logic         ov;
        logic         cs;
        logic         miso;
        logic         busy;
        logic [127:0] ct;
    } obs_t;

    function automatic obs_t obs(input int id);
        obs_t o;
        if (id == 0) o = {if0.in_ready, if0.out_valid, if0.cs, if0.miso, if0.busy, if0.ciphertext};
        else         o = {if5.in_ready, if5.out_valid, if5.cs, if5.miso, if5.busy, if5.ciphertext};
        return o;
    endfunction

    task automatic drive(input int id, input logic iv, input logic [127:0] pt, input logic [127:0] key,
                         input logic ordy);
        if (id == 0) begin
            if0.in_valid = iv; if0.plaintext = pt; if0.key = key; if0.out_ready = ordy;
        end else begin
            if5.in_valid = iv; if5.plaintext = pt; if5.key = key; if5.out_ready = ordy;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    typedef struct {
        int           id;
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           hold;
        int           lat;
    } vec_t;

    vec_t vecs [8];

    task automatic run_vec(input vec_t v, input string tag);
        obs_t o;
        int   lat;
        int   bad;
        @(negedge clk);
        o = obs(v.id);
        chk({tag, "_ready"}, o.ir, 1'b1);
        drive(v.id, 1'b1, v.pt, v.key, 1'b0);
        lat = 0;
        bad = 0;
        do begin
            @(negedge clk);
            lat++;
            o = obs(v.id);
            if (o.ir || !o.busy || (o.cs !== o.ov)) bad++;
            if (!o.ov) drive(v.id, 1'($urandom_range(0, 1)), rnd128(), rnd128(), 1'($urandom_range(0, 1)));
            else       drive(v.id, 1'b0, rnd128(), rnd128(), 1'b0);
        end while (!o.ov && lat < 1000);
        chk({tag, "_latency"}, lat, v.lat);
        chk({tag, "_ct"}, o.ct, v.ct);
        chk({tag, "_busy_phase"}, bad, 0);
        for (int i = 0; i < v.hold; i++) begin
            @(negedge clk);
            o = obs(v.id);
            chk({tag, "_hold"}, {o.ov, o.ir, o.cs, o.ct}, {1'b1, 1'b0, 1'b1, v.ct});
        end
        drive(v.id, 1'b0, rnd128(), rnd128(), 1'b1);
        @(negedge clk);
        o = obs(v.id);
        drive(v.id, 1'b0, rnd128(), rnd128(), 1'b0);
        chk({tag, "_idle"}, {o.ir, o.ov, o.cs, o.busy, o.miso, o.ct}, {5'b10100, v.ct});
        chk({tag, "_frame_len"}, c_frame[v.id], v.lat - 1);
        chk({tag, "_miso_bits"}, c_last[v.id], {v.key, v.pt});
    endtask

    initial begin
        obs_t o;
        int acc, ovc, both, gapbad, ctbad, last_acc, cyc, ovs;

        build_sbox();
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        if0.mosi = 1'b0;
        if5.mosi = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_state_w0", obs(0), {5'b10100, 128'h0});
        chk("reset_state_w5", obs(1), {5'b10100, 128'h0});
        rst = 1'b0;

        chk("model_fips", aes_enc(FIPS_PT, FIPS_KEY), 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        vecs[0] = '{0, FIPS_PT, FIPS_KEY, FIPS_CT, 10, 385};
        vecs[1] = '{0, 128'h1, {1'b1, 127'b0}, aes_enc(128'h1, {1'b1, 127'b0}), 1, 385};
        vecs[2] = '{1, FIPS_PT, FIPS_KEY, FIPS_CT, 2, 390};
        for (int i = 3; i < 8; i++) begin
            vecs[i].id   = $urandom_range(0, 1);
            vecs[i].pt   = rnd128();
            vecs[i].key  = rnd128();
            vecs[i].ct   = aes_enc(vecs[i].pt, vecs[i].key);
            vecs[i].hold = $urandom_range(0, 3);
            vecs[i].lat  = 385 + 5 * vecs[i].id;
        end
        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during SEND bit 100 aborts cleanly.
        @(negedge clk);
        drive(0, 1'b1, FIPS_PT, FIPS_KEY, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, '0, '0, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_state", obs(0), {5'b10100, 128'h0});
        ovs = 0;
        repeat (400) begin
            @(negedge clk);
            if (if0.out_valid) ovs++;
        end
        chk("abort_no_out_valid", ovs, 0);
        run_vec(vecs[0], "after_abort");

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        drive(0, 1'b1, FIPS_PT, FIPS_KEY, 1'b1);
        acc = 0; ovc = 0; both = 0; gapbad = 0; ctbad = 0; last_acc = -1; cyc = 0;
        while (ovc < 3 && cyc < 2000) begin
            o = obs(0);
            if (o.ir) begin
                acc++;
                if (last_acc >= 0 && cyc - last_acc != 386) gapbad++;
                last_acc = cyc;
            end
            if (o.ov) begin
                ovc++;
                if (o.ct !== FIPS_CT) ctbad++;
            end
            if ((o.ir && o.ov) || (o.ir && !o.cs)) both++;
            if (ovc < 3) begin
                @(negedge clk);
                cyc++;
            end
        end
        drive(0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, '0, '0, 1'b0);
        chk("b2b_accepts", acc, 3);
        chk("b2b_results", ovc, 3);
        chk("b2b_gap", gapbad, 0);
        chk("b2b_overlap", both, 0);
        chk("b2b_ct", ctbad, 0);
        chk("b2b_frame_len", c_frame[0], 384);
        chk("b2b_idle", obs(0), {5'b10100, FIPS_CT});

        chk("miso_quiet_w0", miso_bad[0], 0);
        chk("miso_quiet_w5", miso_bad[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
